load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-side responder for the decode stage's data-memory controls (DATA_MEMORY_WR_EN, DATA_MEMORY_SIZE_SEL, DATA_MEMORY_SIGN_EXTEND).
- Accepts one load/store request at a time and runs it on a word-wide data-memory bus with byte enables.
- Returns extended load data, or an error, to the writeback mux input RF_DATA_IN_MUX_SEL=2'b10.
- Handles lane steering, misalignment detection and bus timeout.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in REQ+WAIT before the access aborts with an error; 0 disables the timeout
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W

Ports:
clock  input  1  single clock; all state updates on posedge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1=store, 0=load (from DATA_MEMORY_WR_EN)
req_size  input  2  0=byte, 1=half, 3=word, 2=treated as word (from DATA_MEMORY_SIZE_SEL)
req_unsigned  input  1  from DATA_MEMORY_SIGN_EXTEND, which decode asserts for LBU/LHU; 1=zero-extend, 0=sign-extend
req_address  input  32  byte address (ALU result)
req_wdata  input  32  store data (rs2), low bits significant
mem_valid  output  1  bus request
mem_ready  input  1  bus accepts request
mem_write  output  1  bus write strobe
mem_address  output  32  word-aligned address, {req_address[31:2],2'b00}
mem_byte_en  output  4  lane enables
mem_wdata  output  32  lane-steered store data
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data word
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_error  output  1  valid with resp_valid: misaligned or timeout
resp_misaligned  output  1  valid with resp_valid: the error cause was misalignment

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset (async, reset_n=0): state=IDLE immediately, mid-transaction included. All outputs are 0 except req_ready=1. The timeout counter and latched request are cleared. An in-flight bus read response arriving after reset is ignored.
- IDLE: req_ready=1. On req_valid, latch write/size/unsigned/address/wdata.
  - Misaligned request (half with addr[0]=1, word/size2 with addr[1:0]!=0): go to RESP with resp_error=1, resp_misaligned=1. No bus access is issued.
  - Aligned request: go to REQ.
- REQ: mem_valid=1. mem_write, mem_address, mem_byte_en and mem_wdata are held stable until mem_ready.
  - On mem_ready with a store: go to RESP (no error).
  - On mem_ready with a load: go to WAIT.
- WAIT: mem_valid=0. On mem_rvalid, capture and extend mem_rdata, then go to RESP. mem_rvalid outside WAIT is ignored.
- RESP: resp_valid=1 for exactly one cycle; resp_* are registered and stable in that cycle. Next state is IDLE. A new request can be accepted the cycle after RESP, so back-to-back throughput is one access per 3 cycles minimum for stores and 4 for loads.
- Minimum latency from the acceptance edge: store with immediate mem_ready gives resp_valid 2 cycles later. Load with ready and then rvalid on the next cycle gives resp_valid 3 cycles later. Misaligned request gives resp_valid 1 cycle later.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
- Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extraction:
  - byte lane = rdata[8*addr[1:0]+:8]
  - half lane = rdata[16*addr[1]+:16]
  - Extend by req_unsigned: zero-extend if 1, sign-extend from the lane MSB if 0. Word loads ignore req_unsigned.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When the count reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES!=0), go to RESP with resp_error=1, resp_misaligned=0, resp_rdata=0, and drop mem_valid.
  - If mem_ready or mem_rvalid arrives in the same cycle as the count reaching TIMEOUT_CYCLES, the bus event wins and the access completes normally.
- Inputs on req_* while not in IDLE are ignored; the latched copy is used throughout.

Test Plan:
- Aligned SW at addr 0x100, wdata 0xDEADBEEF, mem_ready=1 immediately → mem_address=0x100, byte_en=4'b1111, mem_wdata=0xDEADBEEF, mem_write=1; resp_valid 2 cycles after acceptance, resp_error=0, resp_rdata=0.
- LB at 0x203 with mem_rdata=0x80FF7F01, unsigned=0 → byte_en=4'b1000, resp_rdata=0xFFFFFF80. LBU (unsigned=1) at the same address → 0x00000080. LH at 0x202 → 0xFFFF80FF.
- SB at 0x001, wdata 0x000000A5 → byte_en=4'b0010, mem_wdata=0xA5A5A5A5. SH at 0x002, wdata 0x1234 → byte_en=4'b1100, mem_wdata=0x12341234.
- LW at 0x102 → no mem_valid ever; resp_valid 1 cycle after acceptance with resp_error=1, resp_misaligned=1. SH at 0x005 → same error response.
- LW at 0x40 with mem_ready held 0, TIMEOUT_CYCLES=16 → mem_valid high for 16 cycles, then resp_error=1, resp_misaligned=0. Repeat with mem_ready rising in the 16th cycle → normal completion.
- reset_n pulsed low while in WAIT → mem_valid=0, req_ready=1 asynchronously. A later mem_rvalid produces no resp_valid. The next LW at 0x0 completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store responder on a word-wide
// data-memory bus. Handles lane steering, load extension, misalignment and
// bus timeout.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; request fields latched on acceptance
// REQ   | bus request driven, waiting for mem_ready
// WAIT  | load issued, waiting for mem_rvalid
// RESP  | one-cycle completion pulse with registered response
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        resp_misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  // Count value seen in the last REQ/WAIT cycle before the abort fires.
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              lat_write, lat_uns;
  logic [1:0]        lat_size;
  logic [31:0]       lat_addr, lat_wdata;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic              err_q, mis_q;

  logic              misaligned_in, timeout_hit;
  logic [31:0]       rd_shift, load_ext;
  logic [3:0]        be_lat;
  logic [31:0]       wdata_lat;

  assign misaligned_in = ((req_size == 2'd1) && req_address[0]) ||
                         (req_size[1] && (req_address[1:0] != 2'b00));
  // Once the count passes the last allowed cycle the abort stays pending,
  // so a load that left REQ late still times out in its first WAIT cycle.
  assign timeout_hit   = TO_EN && (cnt_q >= TC_LAST);

  // Aligned halves have addr[0]=0, so one byte-granular shift serves all sizes.
  assign rd_shift = mem_rdata >> {lat_addr[1:0], 3'b000};

  // Lane extraction and extension of the returned read word.
  always_comb begin
    load_ext = rd_shift;
    case (lat_size)
      2'd0:    load_ext = {{24{~lat_uns & rd_shift[7]}},  rd_shift[7:0]};
      2'd1:    load_ext = {{16{~lat_uns & rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // Byte enables and replicated store data for the latched request.
  always_comb begin
    be_lat    = 4'b1111;
    wdata_lat = lat_wdata;
    case (lat_size)
      2'd0: begin
        be_lat    = 4'b0001 << lat_addr[1:0];
        wdata_lat = {4{lat_wdata[7:0]}};
      end
      2'd1: begin
        be_lat    = 4'b0011 << {lat_addr[1], 1'b0};
        wdata_lat = {2{lat_wdata[15:0]}};
      end
      default: begin
        be_lat    = 4'b1111;
        wdata_lat = lat_wdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a bus event in the same cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = misaligned_in ? S_RESP : S_REQ;
      S_REQ: begin
        if (mem_ready)        state_d = lat_write ? S_RESP : S_WAIT;
        else if (timeout_hit) state_d = S_RESP;
      end
      S_WAIT: if (mem_rvalid || timeout_hit) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, timeout counter and registered response fields.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_write <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (req_valid) begin
            lat_write <= req_write;
            lat_uns   <= req_unsigned;
            lat_size  <= req_size;
            lat_addr  <= req_address;
            lat_wdata <= req_wdata;
            rdata_q   <= '0;
            err_q     <= misaligned_in;
            mis_q     <= misaligned_in;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (!mem_ready && timeout_hit) err_q <= 1'b1;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_rvalid)       rdata_q <= load_ext;
          else if (timeout_hit) err_q   <= 1'b1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Outputs decoded from state; bus and response fields are zero when idle.
  always_comb begin
    req_ready       = (state_q == S_IDLE);
    mem_valid       = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_byte_en     = '0;
    mem_wdata       = '0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_error      = 1'b0;
    resp_misaligned = 1'b0;
    if (state_q == S_REQ) begin
      mem_valid   = 1'b1;
      mem_write   = lat_write;
      mem_address = {lat_addr[31:2], 2'b00};
      mem_byte_en = be_lat;
      mem_wdata   = wdata_lat;
    end
    if (state_q == S_RESP) begin
      resp_valid      = 1'b1;
      resp_rdata      = rdata_q;
      resp_error      = err_q;
      resp_misaligned = mis_q;
    end
  end

endmodule
